// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: LdStCtrl encodings, FSM states and store lane helpers
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        LDST_LB  = 3'd0,
        LDST_LH  = 3'd1,
        LDST_LW  = 3'd2,
        LDST_LBU = 3'd3,
        LDST_LHU = 3'd4,
        LDST_SB  = 3'd5,
        LDST_SH  = 3'd6,
        LDST_SW  = 3'd7
    } ldst_e;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

    function automatic logic is_store(ldst_e op);
        return op inside {LDST_SB, LDST_SH, LDST_SW};
    endfunction

    function automatic logic is_half(ldst_e op);
        return op inside {LDST_LH, LDST_LHU, LDST_SH};
    endfunction

    function automatic logic is_word(ldst_e op);
        return op inside {LDST_LW, LDST_SW};
    endfunction

    function automatic logic misaligned(ldst_e op, logic [1:0] off);
        return (is_half(op) && off[0]) || (is_word(op) && off != 2'b00);
    endfunction

    // Big-endian lanes: byte offset 0 is bit 3 of the enable
    function automatic logic [3:0] lane_be(ldst_e op, logic [1:0] off);
        return is_word(op) ? 4'b1111 : is_half(op) ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> off;
    endfunction

    function automatic logic [31:0] lane_data(ldst_e op, logic [31:0] d);
        return is_word(op) ? d : is_half(op) ? {2{d[15:0]}} : {4{d[7:0]}};
    endfunction

endpackage

// File: rtl/mem_access_unit_aligner.sv
// load_aligner: extracts and sign/zero-extends a load from a big-endian word
module load_aligner
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  ldst_e       op,
    output logic [31:0] result
);

    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;

    // Shift the addressed byte to the top lane, then pick and extend by op
    always_comb begin
        sh = rdata << {offset, 3'b000};
        b = sh[31:24];
        h = offset[1] ? rdata[15:0] : rdata[31:16];
        result = op == LDST_LB  ? {{24{b[7]}}, b} :
                 op == LDST_LBU ? {24'd0, b} :
                 op == LDST_LH  ? {{16{h[15]}}, h} :
                 op == LDST_LHU ? {16'd0, h} : rdata;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store execution over a req/gnt/rvalid data-memory port
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [2:0]        req_ldst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              req_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    state_e      state;
    ldst_e       op;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] cnt;
    logic [31:0] ld_data;
    ldst_e       in_op;

    assign in_op = ldst_e'(req_ldst);

    load_aligner u_aligner (
        .rdata  (dmem_rdata),
        .offset (off),
        .op     (op),
        .result (ld_data)
    );

    // Access FSM; every output is registered, pulses clear themselves each cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op           <= LDST_LB;
            off          <= 2'd0;
            rd           <= 5'd0;
            cnt          <= 32'd0;
            req_ready    <= 1'b1;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= 4'd0;
            dmem_wdata   <= 32'd0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'd0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && misaligned(in_op, req_addr[1:0])) begin
                        misalign_err <= 1'b1;
                    end else if (req_valid) begin
                        state      <= REQ;
                        op         <= in_op;
                        off        <= req_addr[1:0];
                        rd         <= req_rd;
                        req_ready  <= 1'b0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store(in_op);
                        dmem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        dmem_be    <= lane_be(in_op, req_addr[1:0]);
                        dmem_wdata <= is_store(in_op) ? lane_data(in_op, req_wdata) : 32'd0;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        state      <= dmem_we ? IDLE : WAIT_RSP;
                        req_ready  <= dmem_we;
                        cnt        <= 32'd0;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= '0;
                        dmem_be    <= 4'd0;
                        dmem_wdata <= 32'd0;
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rvalid) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        wb_valid  <= 1'b1;
                        wb_rd     <= rd;
                        wb_data   <= ld_data;
                    end else if (TIMEOUT_CYC != 0 && cnt == TO_LAST) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        bus_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_ldst = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        req_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYC(255)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ldst     (req_ldst),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .req_ready    (req_ready),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single cycle; returns #1 into the following cycle
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1;
        req_ldst = op;
        req_addr = addr;
        req_wdata = wd;
        req_rd = rd;
        tick();
        req_valid = 1'b0;
    endtask

    // Load with immediate grant and data one cycle later; returns in the wb_valid cycle
    task automatic quick_load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] rdata);
        issue(op, addr, 32'd0, rd);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_misalign", misalign_err, 0);
        chk("rst_bus_err", bus_err, 0);
        rst_n = 1'b1;
        tick();

        issue(3'd7, 32'h100, 32'hDEADBEEF, 5'd0);
        dmem_gnt = 1'b1;
        chk("sw_req", dmem_req, 1);
        chk("sw_we", dmem_we, 1);
        chk("sw_addr", dmem_addr, 32'h100);
        chk("sw_be", dmem_be, 4'b1111);
        chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("sw_ready_busy", req_ready, 0);
        tick();
        dmem_gnt = 1'b0;
        chk("sw_ready_c2", req_ready, 1);
        chk("sw_req_drop", dmem_req, 0);

        issue(3'd5, 32'h103, 32'h000000A5, 5'd0);
        dmem_gnt = 1'b1;
        chk("sb_be", dmem_be, 4'b0001);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("sb_addr", dmem_addr, 32'h100);
        tick();
        dmem_gnt = 1'b0;

        issue(3'd6, 32'h102, 32'h0000BEEF, 5'd0);
        dmem_gnt = 1'b1;
        chk("sh_be", dmem_be, 4'b0011);
        chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
        tick();
        dmem_gnt = 1'b0;

        issue(3'd0, 32'h101, 32'd0, 5'd5);
        chk("lb_we", dmem_we, 0);
        chk("lb_addr", dmem_addr, 32'h100);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h1280FFFF;
        chk("lb_wait_ready", req_ready, 0);
        tick();
        dmem_rvalid = 1'b0;
        chk("lb_wb_valid", wb_valid, 1);
        chk("lb_wb_data", wb_data, 32'hFFFFFF80);
        chk("lb_wb_rd", wb_rd, 5);
        chk("lb_ready_c3", req_ready, 1);
        tick();
        chk("lb_wb_pulse", wb_valid, 0);

        quick_load(3'd3, 32'h101, 5'd6, 32'h1280FFFF);
        chk("lbu_wb_data", wb_data, 32'h00000080);
        chk("lbu_wb_rd", wb_rd, 6);

        quick_load(3'd1, 32'h102, 5'd7, 32'h0000F00D);
        chk("lh_wb_data", wb_data, 32'hFFFFF00D);

        quick_load(3'd4, 32'h100, 5'd8, 32'h80015555);
        chk("lhu_wb_data", wb_data, 32'h00008001);

        quick_load(3'd2, 32'h104, 5'd10, 32'hCAFEF00D);
        chk("lw_wb_data", wb_data, 32'hCAFEF00D);

        issue(3'd2, 32'h101, 32'd0, 5'd3);
        chk("mis_pulse", misalign_err, 1);
        chk("mis_no_req", dmem_req, 0);
        chk("mis_ready", req_ready, 1);
        tick();
        chk("mis_pulse_end", misalign_err, 0);
        chk("mis_no_req2", dmem_req, 0);

        issue(3'd2, 32'h200, 32'd0, 5'd9);
        dmem_rvalid = 1'b1;
        req_valid = 1'b1;
        req_ldst = 3'd7;
        req_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            chk("dly_req", dmem_req, 1);
            chk("dly_addr", dmem_addr, 32'h200);
            chk("dly_ready", req_ready, 0);
            chk("dly_no_wb", wb_valid, 0);
            tick();
        end
        req_valid = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_gnt = 1'b1;
        chk("dly_req_gnt", dmem_req, 1);
        tick();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h11223344;
        chk("dly_ready_wait", req_ready, 0);
        tick();
        dmem_rvalid = 1'b0;
        chk("dly_wb_valid", wb_valid, 1);
        chk("dly_wb_data", wb_data, 32'h11223344);
        chk("dly_wb_rd", wb_rd, 9);
        chk("dly_ready_back", req_ready, 1);

        issue(3'd2, 32'h300, 32'd0, 5'd11);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        chk("to_no_err_yet", bus_err, 0);
        chk("to_busy", req_ready, 0);
        tick();
        chk("to_bus_err", bus_err, 1);
        chk("to_no_wb", wb_valid, 0);
        chk("to_ready", req_ready, 1);
        tick();
        chk("to_pulse_end", bus_err, 0);

        issue(3'd2, 32'h400, 32'd0, 5'd12);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", req_ready, 1);
        chk("mrst_req", dmem_req, 0);
        chk("mrst_addr", dmem_addr, 0);
        chk("mrst_wb", wb_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h55555555;
        tick();
        dmem_rvalid = 1'b0;
        chk("late_rvalid_wb", wb_valid, 0);
        chk("late_rvalid_ready", req_ready, 1);
        tick();
        chk("late_rvalid_wb2", wb_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Executes the load/store operations that the control unit decodes.
- Consumes the 3-bit LdStCtrl code, effective address and store data from the EX stage.
- Drives a req/gnt/rvalid data-memory port with word address and byte enables.
- Returns aligned, sign- or zero-extended load data to writeback, and holds the pipeline stalled (req_ready low) while an access is outstanding.

Parameters:
- ADDR_W, 32: width of req_addr and dmem_addr.
- TIMEOUT_CYC, 255: maximum cycles in WAIT_RSP before the unit aborts with bus_err. 0 disables the timeout.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  EX stage presents a memory op
- req_ldst  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
- req_addr  in  ADDR_W  effective byte address
- req_wdata  in  32  rt value for stores
- req_rd  in  5  load destination register
- req_ready  out  1  unit can accept; a request is accepted when req_valid && req_ready
- dmem_req  out  1  memory request
- dmem_we  out  1  1 for store
- dmem_addr  out  ADDR_W  word address, bits [1:0] = 0
- dmem_be  out  4  byte enables, bit3 = data[31:24]
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  memory accepts the request this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load word
- wb_valid  out  1  one-cycle pulse, load result ready
- wb_rd  out  5  destination register
- wb_data  out  32  extended load result
- misalign_err  out  1  one-cycle pulse on a misaligned request
- bus_err  out  1  one-cycle pulse on response timeout

Behaviour:
- Byte order is big-endian: byte offset 0 is data[31:24].
- Reset values: every output 0 except req_ready, which resets to 1. The FSM resets to IDLE.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE:
  - req_ready = 1.
  - On accept of an aligned request: latch op, addr, data and rd; go to REQ.
  - Misaligned request (halfword with addr[0] = 1, word with addr[1:0] != 0): pulse misalign_err next cycle. No dmem access; stay in IDLE.
- REQ:
  - dmem_req = 1, with dmem_we/addr/be/wdata held stable until dmem_gnt.
  - Store and gnt: go to IDLE.
  - Load and gnt: go to WAIT_RSP and clear the timeout counter.
- WAIT_RSP:
  - dmem_rvalid is legal no earlier than the cycle after gnt.
  - On rvalid: register the extracted data into wb_data, pulse wb_valid with wb_rd, go to IDLE.
  - Counter reaches TIMEOUT_CYC with no rvalid: pulse bus_err, wb_valid stays 0, go to IDLE.
- Store data and enables:
  - SB: wdata = {4{b}}, be = 4'b1000 >> addr[1:0].
  - SH: wdata = {2{h}}, be = addr[1] ? 0011 : 1100.
  - SW: be = 1111.
- Load extraction:
  - Byte = rdata[31-8*off -: 8]; halfword = addr[1] ? rdata[15:0] : rdata[31:16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Ignored inputs: dmem_rvalid in IDLE or REQ, and dmem_gnt outside REQ. Neither changes state.
- req_ready is 0 in REQ and WAIT_RSP. req_valid arriving then is not accepted.
- Latency:
  - Load with immediate gnt and rvalid one cycle later: accept at cycle 0, req at 1, rvalid at 2, wb_valid at 3, req_ready high at 3.
  - Store with immediate gnt: req_ready high again at cycle 2.
- Reset asserted mid-access: immediate return to IDLE with all outputs at reset values. A response arriving after reset release is ignored.

Decomposition:
- Shared header mem_defs.vh holds:
  - LdStCtrl encodings LDST_LB … LDST_SW, shared with ControlUnit.
  - The FSM state constants.
- One combinational sub-module, load_aligner (rdata, offset, op → 32-bit result), so the extraction logic is reused by any future cache.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, gnt immediate → dmem_addr 0x100, be 1111, we 1; req_ready back at cycle 2.
- SB addr 0x103, wdata 0x000000A5 → be 0001, dmem_wdata 0xA5A5A5A5, dmem_addr 0x100.
- LB addr 0x101, rdata 0x1280FFFF → wb_data 0xFFFFFF80; LBU same stimulus → 0x00000080. wb_rd matches req_rd.
- LH addr 0x102, rdata 0x0000F00D → wb_data 0xFFFFF00D; LW addr 0x101 → misalign_err pulse, no dmem_req.
- Load with gnt delayed 3 cycles → dmem_req and address held stable throughout, req_ready low until wb_valid. No rvalid for TIMEOUT_CYC cycles → bus_err pulse, no wb_valid.
- rst_n dropped while in WAIT_RSP → outputs zero, req_ready 1. Late rvalid after release → no wb_valid.
